gray_counter_ud: RTL

Parametrised up/down Gray-code counter. Successor to the basic enable-only Gray counter.
- Registers binary and Gray values in the same cycle, so the two are always aligned with zero lag.
- Adds direction control, synchronous load of a Gray-coded value, and a selectable wrap or saturate mode.
- Adds registered wrap and saturation event pulses.
- Used as a pointer/sequence source wherever a value crosses into another clock domain (FIFO pointers, position counters).

---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray2bin_n.sv | 21 ++
 rtl/gray_counter_ud.sv | 97 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for pointer and sequence counters.
// The functions are 32 bits wide; narrower values work when zero-extended.
package gray_pkg;

  localparam int GRAY_MAX_BITS = 32;

  typedef logic [GRAY_MAX_BITS-1:0] gray_word_t;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_e;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down. Leading zeros in a narrow value decode to zeros.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_BITS-1] = g[GRAY_MAX_BITS-1];
    for (int i = GRAY_MAX_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary decoder of width N_BITS, zero latency.
// Also usable after a CDC synchroniser on a received Gray pointer.
module gray2bin_n #(
  parameter int N_BITS = 4
) (
  input  logic [N_BITS-1:0] gray_i,
  output logic [N_BITS-1:0] bin_o
);

  logic acc;

  always_comb begin
    acc   = 1'b0;
    bin_o = '0;
    for (int i = N_BITS - 1; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule

// File: rtl/gray_counter_ud.sv
// Up/down Gray counter with Gray load, wrap or saturate mode, and event pulses.
// One-cycle latency from ena/load to every output; binary and Gray register together.
module gray_counter_ud
  import gray_pkg::*;
#(
  parameter int N_BITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ena,
  input  logic              up_dn,
  input  logic              load,
  input  logic [N_BITS-1:0] load_gray,
  output logic [N_BITS-1:0] gray_cnt,
  output logic [N_BITS-1:0] bin_cnt,
  output logic              wrap,
  output logic              sat
);

  if (N_BITS < 2 || N_BITS > GRAY_MAX_BITS) begin : g_bad_width
    $fatal(1, "gray_counter_ud: N_BITS must be in 2..32");
  end

  localparam logic [N_BITS-1:0] MAX_VAL = {N_BITS{1'b1}};
  localparam logic [N_BITS-1:0] ONE     = N_BITS'(1);

  logic [N_BITS-1:0] bin_q, bin_d;
  logic [N_BITS-1:0] gray_q, gray_d;
  logic              wrap_q, wrap_d;
  logic              sat_q, sat_d;
  logic [N_BITS-1:0] load_bin;
  logic              at_max, at_zero;
  cnt_dir_e          dir;

  gray2bin_n #(
    .N_BITS(N_BITS)
  ) u_load_dec (
    .gray_i(load_gray),
    .bin_o (load_bin)
  );

  assign dir     = cnt_dir_e'(up_dn);
  assign at_max  = (bin_q == MAX_VAL);
  assign at_zero = (bin_q == '0);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (ena) begin
      if (dir == CNT_UP) begin
        if (!at_max) begin
          bin_d = bin_q + ONE;
        end else if (WRAP) begin
          bin_d  = '0;
          wrap_d = 1'b1;
        end else begin
          sat_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          bin_d = bin_q - ONE;
        end else if (WRAP) begin
          bin_d  = MAX_VAL;
          wrap_d = 1'b1;
        end else begin
          sat_d = 1'b1;
        end
      end
    end
    // Encode from the next binary value so both registers stay aligned.
    gray_d = N_BITS'(bin2gray(gray_word_t'(bin_d)));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign gray_cnt = gray_q;
  assign bin_cnt  = bin_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;

endmodule
